// File: rtl/fpu_host_link_pkg.sv
// Shared types and constants for the FPU host link: FSM encoding, transfer sizes,
// and the operand byte-order helper used by the SEND multiplexer.
package fpu_host_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_HOLD = 3'd4
  } link_state_e;

  localparam int unsigned IN_BYTES        = 16;
  localparam int unsigned OUT_BYTES       = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Operands are packed {d, c, b, a}, so wire byte 0 (d[31:24]) is the top slot.
  function automatic logic [7:0] send_byte(input logic [127:0] ops, input logic [3:0] idx);
    logic [3:0] slot;
    slot = 4'd15 - idx;
    return ops[{slot, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fpu_link_watchdog.sv
// Result-toggle edge detector and WAIT timeout counter. The toggle reference is
// re-captured on every accepted command so toggles left over from earlier work are not counted.
module fpu_link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = fpu_host_link_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic snap_i,
  input  logic tog_i,
  input  logic active_i,
  output logic toggle_o,
  output logic timeout_o
);

  logic        tog_ref_q, tog_ref_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tog_ref_d = snap_i ? tog_i : tog_ref_q;
    cnt_d     = active_i ? cnt_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tog_ref_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      tog_ref_q <= tog_ref_d;
      cnt_q     <= cnt_d;
    end
  end

  // Only meaningful while the link sits in WAIT; elsewhere both are forced low.
  assign toggle_o  = active_i && (tog_i != tog_ref_q);
  assign timeout_o = active_i && (cnt_d == 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/fpu_host_link.sv
// Host-side link to a byte-serial FPU computing a*b + c*d: streams 16 operand
// bytes out, waits for the result toggle, collects 4 result bytes and holds the response.
module fpu_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = fpu_host_link_pkg::TIMEOUT_DEFAULT,
  parameter int unsigned IN_BYTES       = fpu_host_link_pkg::IN_BYTES,
  parameter int unsigned OUT_BYTES      = fpu_host_link_pkg::OUT_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] op_c,
  input  logic [31:0] op_d,
  output logic [7:0]  dev_data_out,
  input  logic [7:0]  dev_data_in,
  input  logic [3:0]  dev_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);
  import fpu_host_link_pkg::*;

  localparam logic [3:0] SEND_LAST = 4'(IN_BYTES - 1);
  localparam logic [3:0] RECV_LAST = 4'(OUT_BYTES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a held response keeps rsp_valid/rsp_data/rsp_err constant until then.
  link_state_e  state_q, state_d;
  logic [127:0] ops_q, ops_d;
  logic [3:0]   idx_q, idx_d;
  logic [31:0]  rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;
  logic         cmd_fire, wait_active, toggle, timeout;
  logic         unused_status;

  assign cmd_fire      = (state_q == ST_IDLE) && cmd_valid;
  assign wait_active   = (state_q == ST_WAIT);
  assign unused_status = ^dev_status[3:2];

  fpu_link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .snap_i    (cmd_fire),
    .tog_i     (dev_status[1]),
    .active_i  (wait_active),
    .toggle_o  (toggle),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_SEND;
      ST_SEND: if (idx_q == SEND_LAST) state_d = ST_WAIT;
      ST_WAIT: begin
        if (toggle)       state_d = ST_RECV;
        else if (timeout) state_d = ST_HOLD;
      end
      ST_RECV: if (!dev_status[0] || idx_q == RECV_LAST) state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    rsp_valid    = (state_q == ST_HOLD);
    rsp_data     = rsp_data_q;
    rsp_err      = rsp_err_q;
    dev_data_out = (state_q == ST_SEND) ? send_byte(ops_q, idx_q) : 8'h00;
  end

  // The byte index is shared: wire position in SEND, result byte lane in RECV.
  always_comb begin
    ops_d      = ops_q;
    idx_d      = 4'd0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ops_d      = {op_d, op_c, op_b, op_a};
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b0;
        end
      end
      ST_SEND: idx_d = idx_q + 4'd1;
      ST_WAIT: begin
        if (!toggle && timeout) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b1;
        end
      end
      ST_RECV: begin
        if (!dev_status[0]) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d[{idx_q[1:0], 3'b000} +: 8] = dev_data_in;
          idx_d = idx_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q      <= '0;
      idx_q      <= 4'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      ops_q      <= ops_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: doc/fpu_host_link.md
FPU_HOST_LINK -- requirements
Module: fpu_host_link

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles spent in WAIT before error.
REQ-002 Parameter IN_BYTES, default 16, is the operand bytes per transaction; fixed at 16.
REQ-003 Parameter OUT_BYTES, default 4, is the result bytes per transaction; fixed at 4.
REQ-004 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port cmd_valid, input, 1: a command is offered.
REQ-007 Port cmd_ready, output, 1: a command is accepted when both cmd_valid and cmd_ready are high.
REQ-008 Ports op_a, op_b, op_c, op_d, input, 32 each: IEEE-754 single-precision operands; the device computes a*b + c*d.
REQ-009 Port dev_data_out, output, 8: byte stream to the FPU device's byte input.
REQ-010 Port dev_data_in, input, 8: byte stream from the FPU device's byte output.
REQ-011 Port dev_status, input, 4: device status; bit0 = result stream active, bit1 = result toggle, bits 3:2 ignored.
REQ-012 Port rsp_valid, output, 1: a response is held.
REQ-013 Port rsp_ready, input, 1: the response is consumed when both rsp_valid and rsp_ready are high.
REQ-014 Port rsp_data, output, 32: assembled result word.
REQ-015 Port rsp_err, output, 1: the response is a timeout or protocol error; rsp_data = 0.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT, RECV and HOLD.
REQ-018 IDLE: cmd_ready = 1; on handshake, latch the four operands, snapshot dev_status[1] into tog_ref, and go to SEND on the next cycle.
REQ-019 SEND: drive exactly 16 bytes on 16 consecutive cycles, one per cycle, in order d[31:24], d[23:16], d[15:8], d[7:0], then c, b, a, each MSB-first; then go to WAIT.
REQ-020 dev_data_out SHALL be 0x00 in every state except SEND.
REQ-021 WAIT: a 16-bit counter increments each cycle; when dev_status[1] != tog_ref, go to RECV with byte index 0.
REQ-022 WAIT timeout: when the counter reaches TIMEOUT_CYCLES, go to HOLD with rsp_err = 1.
REQ-023 RECV: on each of the 4 cycles following toggle detection, capture dev_data_in into rsp_data byte[idx], LSB-first (idx 0 -> bits 7:0), then go to HOLD.
REQ-024 If dev_status[0] is low on any RECV capture cycle, abort to HOLD with rsp_err = 1 and rsp_data = 0.
REQ-025 HOLD: rsp_valid = 1 with rsp_data and rsp_err stable until the handshake; on handshake, go to IDLE.
REQ-026 Back-to-back commands SHALL be supported: cmd_ready rises on the cycle after the response handshake, with no dead cycles beyond that.
REQ-027 cmd_valid SHALL be ignored outside IDLE.
REQ-028 Toggles of dev_status[1] outside WAIT SHALL be ignored.
REQ-029 On each new command, tog_ref SHALL be re-snapshotted so that stale toggles are not counted.
REQ-030 Minimum latency, command handshake to rsp_valid, SHALL be 1 + 16 + (device delay) + 4 + 1 cycles.

Reset
REQ-031 Reset SHALL be asynchronous on rst_n low and released synchronously by the design flow.
REQ-032 Reset values: state = IDLE, cmd_ready = 1 (IDLE), rsp_valid = 0, rsp_err = 0, rsp_data = 0, dev_data_out = 0x00, busy = 0, counters = 0, tog_ref = 0.
REQ-033 Reset mid-transaction SHALL discard all progress; no response is issued for the aborted command.

Structure
REQ-034 A shared package SHALL hold the state enum, IN_BYTES, OUT_BYTES and the default timeout constant.
REQ-035 The toggle-edge detector plus WAIT timeout counter SHALL form a single sub-module, fpu_link_watchdog.
REQ-036 The byte-select multiplexer for SEND SHALL be indexed by a 4-bit counter.
REQ-037 No other sub-modules SHALL be used.

Verification
REQ-038 Nominal: a = 0x40000000, b = 0x40400000, c = d = 0x3F800000; dev_data_out SHALL be 3F 80 00 00 3F 80 00 00 40 40 00 00 40 00 00 00; the device model toggles status then returns 00 00 E0 40; rsp_data SHALL be 0x40E00000 with rsp_err = 0.
REQ-039 Timeout: the device never toggles; with TIMEOUT_CYCLES = 20, rsp_valid = 1 and rsp_err = 1, rsp_data = 0 exactly 20 cycles after entering WAIT.
REQ-040 Stream drop: dev_status[0] falls after 2 result bytes; rsp_err = 1, rsp_data = 0.
REQ-041 Backpressure: hold rsp_ready = 0 for 10 cycles; rsp_data is stable, cmd_ready = 0, and a cmd_valid pulse is ignored.
REQ-042 Reset mid-SEND: assert rst_n low at byte 7; all outputs return to reset values immediately, with no response; a following command completes correctly.
REQ-043 Back-to-back: two commands (7.0 above, then zero operands -> 0x00000000) with rsp_ready tied high yield two responses in order.
